// File: rtl/fft_serializer.sv
// Streams one buffered FFT frame out as one complex sample per send handshake; sample 0 follows accept by one cycle.
// send_val is never retracted on backpressure; a new frame is taken only in IDLE or on the last beat, so frames run back to back with no bubble.
module fft_serializer #(
  parameter int BIT_WIDTH   = 32,
  parameter int DECIMAL_PT  = 16,
  parameter int N_SAMPLES   = 8,
  parameter int BIT_REVERSE = 0
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [N_SAMPLES-1:0][BIT_WIDTH-1:0] recv_msg_real,
  input  logic [N_SAMPLES-1:0][BIT_WIDTH-1:0] recv_msg_imag,
  input  logic                                recv_val,
  output logic                                recv_rdy,
  output logic [BIT_WIDTH-1:0]                send_msg_real,
  output logic [BIT_WIDTH-1:0]                send_msg_imag,
  output logic [$clog2(N_SAMPLES)-1:0]        send_idx,
  output logic                                send_last,
  output logic                                send_val,
  input  logic                                send_rdy
);

  localparam int IDX_W = $clog2(N_SAMPLES);
  localparam logic [IDX_W-1:0] CNT_MAX = IDX_W'(N_SAMPLES - 1);

  if ((N_SAMPLES < 2) || ((N_SAMPLES & (N_SAMPLES - 1)) != 0) || (DECIMAL_PT > BIT_WIDTH)) begin : g_param_check
    $error("fft_serializer: N_SAMPLES must be a power of two >= 2 and DECIMAL_PT <= BIT_WIDTH");
  end

  typedef enum logic {IDLE, SEND} state_t;

  state_t               state, state_next;
  logic [IDX_W-1:0]     cnt, cnt_next;
  logic                 load;
  logic [IDX_W-1:0]     rd_idx;
  logic [BIT_WIDTH-1:0] buf_real [N_SAMPLES];
  logic [BIT_WIDTH-1:0] buf_imag [N_SAMPLES];

  function automatic logic [IDX_W-1:0] bitrev(input logic [IDX_W-1:0] x);
    logic [IDX_W-1:0] r;
    for (int b = 0; b < IDX_W; b++) r[b] = x[IDX_W-1-b];
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      for (int i = 0; i < N_SAMPLES; i++) begin
        buf_real[i] <= '0;
        buf_imag[i] <= '0;
      end
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (load) begin
        for (int i = 0; i < N_SAMPLES; i++) begin
          buf_real[i] <= recv_msg_real[i];
          buf_imag[i] <= recv_msg_imag[i];
        end
      end
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    load       = 1'b0;
    recv_rdy   = 1'b0;
    send_val   = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: begin
          recv_rdy = 1'b1;
          if (recv_val) begin
            load       = 1'b1;
            cnt_next   = '0;
            state_next = SEND;
          end
        end
        SEND: begin
          send_val = 1'b1;
          if (send_rdy) begin
            if (cnt != CNT_MAX) begin
              cnt_next = cnt + IDX_W'(1);
            end else begin
              // Last beat: the only SEND cycle where a new frame may enter.
              recv_rdy = 1'b1;
              cnt_next = '0;
              if (recv_val) load = 1'b1;
              else          state_next = IDLE;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign rd_idx        = (BIT_REVERSE != 0) ? bitrev(cnt) : cnt;
  assign send_msg_real = buf_real[rd_idx];
  assign send_msg_imag = buf_imag[rd_idx];
  assign send_idx      = cnt;
  assign send_last     = (cnt == CNT_MAX);

endmodule

// File: tb/tb_fft_serializer.sv
// Drives a natural-order and a bit-reversed serializer with the same stimulus and scoreboards both against a frame-level model.
module tb_fft_serializer;

  typedef struct {
    logic [31:0] re;
    logic [31:0] im;
    logic [2:0]  idx;
    logic        last;
  } beat_t;

  logic            clk = 1'b0;
  logic            reset;
  logic [7:0][31:0] recv_msg_real;
  logic [7:0][31:0] recv_msg_imag;
  logic            recv_val;
  logic            send_rdy;

  logic            r_rdy  [2];
  logic [31:0]     s_re   [2];
  logic [31:0]     s_im   [2];
  logic [2:0]      s_idx  [2];
  logic            s_last [2];
  logic            s_val  [2];

  beat_t q [2][$];
  int tests = 0;
  int fails = 0;
  int hs_cnt = 0;
  int rdy_mode = 0;
  int pat_ctr = 0;
  int stall_ctr = 0;

  always #5 clk = ~clk;

  fft_serializer #(.BIT_WIDTH(32), .DECIMAL_PT(16), .N_SAMPLES(8), .BIT_REVERSE(0)) u_nat (
    .clk(clk), .reset(reset),
    .recv_msg_real(recv_msg_real), .recv_msg_imag(recv_msg_imag),
    .recv_val(recv_val), .recv_rdy(r_rdy[0]),
    .send_msg_real(s_re[0]), .send_msg_imag(s_im[0]),
    .send_idx(s_idx[0]), .send_last(s_last[0]),
    .send_val(s_val[0]), .send_rdy(send_rdy)
  );

  fft_serializer #(.BIT_WIDTH(32), .DECIMAL_PT(16), .N_SAMPLES(8), .BIT_REVERSE(1)) u_rev (
    .clk(clk), .reset(reset),
    .recv_msg_real(recv_msg_real), .recv_msg_imag(recv_msg_imag),
    .recv_val(recv_val), .recv_rdy(r_rdy[1]),
    .send_msg_real(s_re[1]), .send_msg_imag(s_im[1]),
    .send_idx(s_idx[1]), .send_last(s_last[1]),
    .send_val(s_val[1]), .send_rdy(send_rdy)
  );

  task automatic check(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[inst %0d] t=%0t: got %h expected %h", nm, k, $time, act, exp);
    end
  endtask

  // Monitor: compares every cycle against the frame-level model held in q.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        check("reset_send_val", k, 32'(s_val[k]), 32'd0);
        check("reset_recv_rdy", k, 32'(r_rdy[k]), 32'd0);
        q[k].delete();
      end else begin
        check("recv_rdy", k, 32'(r_rdy[k]),
              32'((q[k].size() == 0) || (q[k].size() == 1 && send_rdy)));
        check("send_val", k, 32'(s_val[k]), 32'(q[k].size() != 0));
        if (q[k].size() == 0) begin
          check("idle_xfree", k, 32'($isunknown(s_re[k]) || $isunknown(s_im[k])), 32'd0);
        end else if (s_val[k]) begin
          check("real", k, s_re[k], q[k][0].re);
          check("imag", k, s_im[k], q[k][0].im);
          check("idx",  k, 32'(s_idx[k]), 32'(q[k][0].idx));
          check("last", k, 32'(s_last[k]), 32'(q[k][0].last));
          if (send_rdy) begin
            void'(q[k].pop_front());
            if (k == 0) hs_cnt++;
          end
        end
      end
    end
  end

  // Downstream ready generator.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: send_rdy = 1'b1;
      1: begin send_rdy = (pat_ctr % 3 == 0); pat_ctr++; end
      2: send_rdy = ($urandom_range(0, 3) != 0);
      default: begin
        if (q[0].size() == 1 && stall_ctr < 4) begin
          send_rdy = 1'b0;
          stall_ctr++;
        end else begin
          send_rdy = 1'b1;
          if (q[0].size() != 1) stall_ctr = 0;
        end
      end
    endcase
  end

  task automatic push_frame(input logic [31:0] re [8], input logic [31:0] im [8]);
    beat_t b;
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 8; j++) begin
        int src;
        src    = (k == 1) ? (((j & 1) << 2) | (j & 2) | ((j >> 2) & 1)) : j;
        b.re   = re[src];
        b.im   = im[src];
        b.idx  = 3'(j);
        b.last = (j == 7);
        q[k].push_back(b);
      end
    end
  endtask

  task automatic send_frame(input logic [31:0] re [8], input logic [31:0] im [8], input bit hold);
    int n;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      recv_msg_real[i] = re[i];
      recv_msg_imag[i] = im[i];
    end
    recv_val = 1'b1;
    @(negedge clk);
    while (!r_rdy[0] && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!r_rdy[0]) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: recv_rdy still 0 after %0d cycles, required 1", n);
      recv_val = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      push_frame(re, im);
      if (!hold) recv_val = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((q[0].size() != 0 || q[1].size() != 0) && n < 500) begin
      @(posedge clk);
      n++;
    end
    if (q[0].size() != 0 || q[1].size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: %0d beats outstanding, required 0", q[0].size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] fa_re [8], fa_im [8], fb_re [8], fb_im [8];
    int base, n;

    reset = 1'b1;
    recv_val = 1'b0;
    send_rdy = 1'b1;
    recv_msg_real = '0;
    recv_msg_imag = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;

    // Directed ramp frame, both orders, full throughput.
    for (int i = 0; i < 8; i++) begin
      fa_re[i] = i + 1;
      fa_im[i] = -(i + 1);
      fb_re[i] = 100 + i;
      fb_im[i] = $urandom;
    end
    send_frame(fa_re, fa_im, 1'b0);
    wait_drain();

    // Backpressure 1,0,0,1,...
    rdy_mode = 1;
    pat_ctr = 0;
    send_frame(fa_re, fa_im, 1'b0);
    wait_drain();

    // Back-to-back with recv_val held through frame 1.
    rdy_mode = 0;
    send_frame(fa_re, fa_im, 1'b1);
    send_frame(fb_re, fb_im, 1'b0);
    wait_drain();

    // Reset after three beats of a frame.
    send_frame(fb_re, fb_im, 1'b0);
    base = hs_cnt;
    n = 0;
    while (hs_cnt < base + 3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    send_frame(fa_re, fa_im, 1'b0);
    wait_drain();

    // Stall on the last beat with the next frame already offered.
    rdy_mode = 3;
    stall_ctr = 0;
    send_frame(fa_re, fa_im, 1'b1);
    send_frame(fb_re, fb_im, 1'b0);
    wait_drain();

    // Random frames, random ready, random gaps and holds.
    rdy_mode = 2;
    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < 8; i++) begin
        fa_re[i] = $urandom;
        fa_im[i] = $urandom;
      end
      send_frame(fa_re, fa_im, 1'($urandom_range(0, 1)));
      if (!recv_val) repeat ($urandom_range(0, 3)) @(posedge clk);
      #0;
    end
    recv_val = 1'b0;
    wait_drain();

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
